// File: rtl/mu0_pkg.sv
// Shared MU0 constants: FSM state encoding, opcodes and ALU function codes.
package mu0_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    EXECUTE = 2'd1,
    HALT    = 2'd2
  } state_e;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] ALU_PASSB = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_SUB   = 2'b10;
  localparam logic [1:0] ALU_INC   = 2'b11;

  // Opcodes that touch memory in EXECUTE and therefore can stall.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mu0_control.sv
// MU0 fetch/execute control FSM with a memory-ready stall handshake.
module mu0_control
  import mu0_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       mem_ready,
  output logic       Asel,
  output logic       Bsel,
  output logic [1:0] ALUfs,
  output logic       ACCce,
  output logic       PCce,
  output logic       IRce,
  output logic       ACCoe,
  output logic       MEMrq,
  output logic       RnW,
  output logic       Halted
);

  state_e state_q, state_d;

  // State register; reset wins from any state, including HALT and stalls.
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and output decode. Stalled cycles keep every select stable
  // and only the enables follow mem_ready.
  always_comb begin
    state_d = state_q;
    Asel    = 1'b0;
    Bsel    = 1'b0;
    ALUfs   = ALU_PASSB;
    ACCce   = 1'b0;
    PCce    = 1'b0;
    IRce    = 1'b0;
    ACCoe   = 1'b0;
    MEMrq   = 1'b0;
    RnW     = 1'b0;
    Halted  = 1'b0;

    unique case (state_q)
      FETCH: begin
        ALUfs = ALU_INC;
        MEMrq = 1'b1;
        RnW   = 1'b1;
        IRce  = mem_ready;
        PCce  = mem_ready;
        if (mem_ready) state_d = EXECUTE;
      end

      EXECUTE: begin
        case (F)
          OP_LDA, OP_ADD, OP_SUB: begin
            Asel  = 1'b1;
            Bsel  = 1'b1;
            MEMrq = 1'b1;
            RnW   = 1'b1;
            ACCce = mem_ready;
            ALUfs = (F == OP_ADD) ? ALU_ADD :
                    (F == OP_SUB) ? ALU_SUB : ALU_PASSB;
          end
          OP_STA: begin
            Asel  = 1'b1;
            MEMrq = 1'b1;
            ACCoe = 1'b1;
          end
          OP_JMP: begin
            Asel = 1'b1;
            PCce = 1'b1;
          end
          OP_JGE: begin
            Asel = !N;
            PCce = !N;
          end
          OP_JNE: begin
            Asel = !Z;
            PCce = !Z;
          end
          default: ;
        endcase

        if (F == OP_STP)                    state_d = HALT;
        else if (!is_mem_op(F) || mem_ready) state_d = FETCH;
      end

      HALT: Halted = 1'b1;

      default: state_d = FETCH;
    endcase

    // Reset masks every output so no write can escape during reset.
    if (Reset) begin
      Asel   = 1'b0;
      Bsel   = 1'b0;
      ALUfs  = 2'b00;
      ACCce  = 1'b0;
      PCce   = 1'b0;
      IRce   = 1'b0;
      ACCoe  = 1'b0;
      MEMrq  = 1'b0;
      RnW    = 1'b0;
      Halted = 1'b0;
    end
  end

endmodule

// File: tb/tb_mu0_control.sv
// Scoreboard bench for mu0_control: stimulus pushes the expected output
// vector for each cycle, a negedge monitor pops and compares.
module tb_mu0_control;

  logic       Clk = 1'b0;
  logic       Reset, N, Z, mem_ready;
  logic [3:0] F;
  logic       Asel, Bsel, ACCce, PCce, IRce, ACCoe, MEMrq, RnW, Halted;
  logic [1:0] ALUfs;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [10:0] v;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  mu0_control dut (
    .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .mem_ready(mem_ready),
    .Asel(Asel), .Bsel(Bsel), .ALUfs(ALUfs), .ACCce(ACCce), .PCce(PCce),
    .IRce(IRce), .ACCoe(ACCoe), .MEMrq(MEMrq), .RnW(RnW), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  // Vector order: Asel Bsel ALUfs[1:0] ACCce PCce IRce ACCoe MEMrq RnW Halted
  function automatic logic [10:0] ev(input logic a, b, input logic [1:0] f,
                                     input logic acc, pc, ir, oe, rq, rw, h);
    return {a, b, f, acc, pc, ir, oe, rq, rw, h};
  endfunction

  localparam logic [10:0] ZERO    = 11'd0;
  localparam logic [10:0] FETCH_W = {1'b0,1'b0,2'b11,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
  localparam logic [10:0] FETCH_R = {1'b0,1'b0,2'b11,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0};
  localparam logic [10:0] LDA_R   = {1'b1,1'b1,2'b00,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
  localparam logic [10:0] ADD_W   = {1'b1,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
  localparam logic [10:0] ADD_R   = {1'b1,1'b1,2'b01,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
  localparam logic [10:0] SUB_R   = {1'b1,1'b1,2'b10,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
  localparam logic [10:0] STA_V   = {1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0};
  localparam logic [10:0] JMP_V   = {1'b1,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [10:0] HALT_V  = {1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};

  // One cycle: drive inputs just after the rising edge, queue the expectation.
  task automatic step(input logic rst, input logic [3:0] f, input logic n, z, mr,
                      input logic [10:0] exp_v, input string nm);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset = rst; F = f; N = n; Z = z; mem_ready = mr;
    e.v = exp_v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge Clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [10:0] act;
      e = sb_q.pop_front();
      act = ev(Asel, Bsel, ALUfs, ACCce, PCce, IRce, ACCoe, MEMrq, RnW, Halted);
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b (Asel Bsel ALUfs ACCce PCce IRce ACCoe MEMrq RnW Halted)",
                 e.name, act, e.v);
      end
    end
  end

  initial begin
    Reset = 1'b1; F = 4'd0; N = 1'b0; Z = 1'b0; mem_ready = 1'b1;

    step(1, 0, 0, 0, 1, ZERO,    "reset0");
    step(1, 0, 0, 0, 1, ZERO,    "reset1");
    step(0, 0, 0, 0, 1, FETCH_R, "fetch_after_reset");
    step(0, 0, 0, 0, 1, LDA_R,   "lda_exec");
    step(0, 1, 0, 0, 1, FETCH_R, "fetch_sta");
    step(0, 1, 0, 0, 0, STA_V,   "sta_stall0");
    step(0, 1, 0, 0, 0, STA_V,   "sta_stall1");
    step(0, 1, 0, 0, 0, STA_V,   "sta_stall2");
    step(0, 1, 0, 0, 1, STA_V,   "sta_done");
    step(0, 5, 1, 0, 1, FETCH_R, "fetch_jge_n1");
    step(0, 5, 1, 0, 1, ZERO,    "jge_not_taken");
    step(0, 5, 0, 0, 1, FETCH_R, "fetch_jge_n0");
    step(0, 5, 0, 0, 1, JMP_V,   "jge_taken");
    step(0, 6, 0, 1, 1, FETCH_R, "fetch_jne_z1");
    step(0, 6, 0, 1, 1, ZERO,    "jne_not_taken");
    step(0, 6, 0, 0, 1, FETCH_R, "fetch_jne_z0");
    step(0, 6, 0, 0, 1, JMP_V,   "jne_taken");
    step(0, 4, 0, 0, 1, FETCH_R, "fetch_jmp");
    step(0, 4, 0, 0, 0, JMP_V,   "jmp_ignores_ready");
    step(0, 9, 0, 0, 1, FETCH_R, "fetch_nop");
    step(0, 9, 0, 0, 1, ZERO,    "nop_exec");
    step(0, 3, 0, 0, 0, FETCH_W, "fetch_wait0");
    step(0, 3, 0, 0, 0, FETCH_W, "fetch_wait1");
    step(0, 3, 0, 0, 1, FETCH_R, "fetch_wait_done");
    step(0, 3, 0, 0, 1, SUB_R,   "sub_exec");
    step(0, 7, 0, 0, 1, FETCH_R, "fetch_stp");
    step(0, 7, 0, 0, 1, ZERO,    "stp_exec");
    for (int i = 0; i < 10; i++)
      step(0, 7, 0, 0, logic'(i[0]), HALT_V, "halt_hold");
    step(1, 7, 0, 0, 1, ZERO,    "reset_from_halt");
    step(0, 2, 0, 0, 1, FETCH_R, "fetch_after_halt");
    step(0, 2, 0, 0, 0, ADD_W,   "add_stall0");
    step(0, 2, 0, 0, 0, ADD_W,   "add_stall1");
    step(1, 2, 0, 0, 1, ZERO,    "reset_mid_stall");
    step(0, 2, 0, 0, 0, FETCH_W, "fetch_after_stall_reset");
    step(0, 2, 0, 0, 1, FETCH_R, "fetch_add");
    step(0, 2, 0, 0, 1, ADD_R,   "add_exec");
    step(0, 0, 0, 0, 1, FETCH_R, "fetch_final");

    @(posedge Clk);
    #1;
    repeat (2) @(negedge Clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
